// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: widths, FSM state
// encoding, error read value, latched access payload and the address check.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Value driven on rdata_o when a load completes with an error
    localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One captured CPU access
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    // Misaligned byte address or word index beyond the storage depth
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the responder.
//   clk_i    : clock
//   we_i     : write enable, word written on rising edge
//   idx_i    : word index (shared by read and write)
//   wdata_i  : write data
//   rdata_o  : asynchronous read of word idx_i
// Contents are not reset.
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory port. Accepts one load or
// store at a time, completes it LATENCY cycles after the request cycle and
// holds the pipeline through stall_o until the one-cycle ack_o.
//   clk_i   : clock            rst_i   : synchronous active-high reset
//   req_i   : access request   we_i    : 1 = store, 0 = load
//   addr_i  : byte address     wdata_i : store data
//   rdata_o : registered load data, held until the next load completes
//   ack_o   : one-cycle completion pulse
//   err_o   : with ack_o, misaligned or out-of-range access
//   stall_o : combinational pipeline hold request
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    acc_t              acc_q, acc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    acc_t              cur_acc;
    logic              cur_err;
    logic              commit;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Access being served: live inputs while idle (needed when LATENCY=1
    // commits straight from IDLE), latched copy otherwise
    always_comb begin
        cur_acc = acc_q;
        if (state_q == ST_IDLE) begin
            cur_acc.we    = we_i;
            cur_acc.addr  = addr_i;
            cur_acc.wdata = wdata_i;
        end
        cur_err = addr_bad(cur_acc.addr, DEPTH_WORDS);
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next state, latency counter and request latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    acc_d.we    = we_i;
                    acc_d.addr  = addr_i;
                    acc_d.wdata = wdata_i;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: commit happens on the edge that enters RESP
    always_comb begin
        commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
        ack_d   = commit;
        err_d   = commit && cur_err;
        mem_we  = commit && cur_acc.we && !cur_err && !rst_i;
        rdata_d = rdata_q;
        if (commit && !cur_acc.we) begin
            rdata_d = cur_err ? ERR_RDATA : mem_rdata;
        end
        stall_o = ((state_q == ST_IDLE) && req_i) || (state_q == ST_WAIT);
    end

    dmem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (cur_acc.addr[IDX_W+1:2]),
        .wdata_i (cur_acc.wdata),
        .rdata_o (mem_rdata)
    );

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 instance exercised with directed and
// random accesses against a transaction-level memory model, and a LATENCY=1
// instance for the single-cycle-latency shape.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_o;
    logic        ack_o, err_o, stall_o;

    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1_o;
    logic        ack1_o, err1_o, stall1_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_m [int];
    logic [31:0] rdata_m;
    logic [31:0] written [$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o),
        .stall_o(stall_o)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .rdata_o(rdata1_o), .ack_o(ack1_o), .err_o(err1_o),
        .stall_o(stall1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // One access on the LATENCY=3 instance; started in the request cycle.
    // keep=1 leaves req high after ack so the next call is back-to-back.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit keep);
        int          seen;
        bit          e;
        logic [31:0] exp_rd;
        e = bad_addr(a);
        exp_rd = rdata_m;
        if (!w) exp_rd = e ? 32'h0 : mem_m[int'(a / 4)];
        req = 1'b1; we = w; addr = a; wdata = d;
        seen = -1;
        for (int k = 0; k < 20 && seen < 0; k++) begin
            #1;
            chk("stall", 32'(stall_o), 32'(k < int'(LAT)));
            if (ack_o === 1'b1) begin
                seen = k;
                chk("err", 32'(err_o), 32'(e));
                chk("rdata", rdata_o, exp_rd);
                if (!keep) req = 1'b0;
            end else if (k > 0) begin
                // Inputs during WAIT must be ignored
                we = 1'($urandom); addr = $urandom; wdata = $urandom;
            end
            tick();
        end
        chk("latency", 32'(seen), 32'(LAT));
        chk("ack_width", 32'(ack_o), 32'h0);
        rdata_m = exp_rd;
        if (w && !e) begin
            mem_m[int'(a / 4)] = d;
            written.push_back(a);
        end
    endtask

    // One access on the LATENCY=1 instance
    task automatic access1(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        #1;
        chk("l1_stall_req", 32'(stall1_o), 32'h1);
        chk("l1_ack_early", 32'(ack1_o), 32'h0);
        tick();
        #1;
        chk("l1_ack", 32'(ack1_o), 32'h1);
        chk("l1_stall_ack", 32'(stall1_o), 32'h0);
        chk("l1_err", 32'(err1_o), 32'h0);
        chk("l1_rdata", rdata1_o, exp_rd);
        req1 = 1'b0;
        tick();
        #1;
        chk("l1_ack_width", 32'(ack1_o), 32'h0);
        chk("l1_stall_idle", 32'(stall1_o), 32'h0);
    endtask

    initial begin
        bit          w;
        logic [31:0] a;
        int          r;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        rdata_m = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst1_rdata", rdata1_o, 32'h0);
        tick();

        // Store then load with latency 3
        access(1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);
        chk("load_cafe", rdata_o, 32'hCAFE_F00D);

        // Errors: misaligned load, out-of-range store must not alias word 0
        access(1'b1, 32'h0, 32'h0BAD_0000, 1'b0);
        access(1'b0, 32'h13, 32'h0, 1'b0);
        access(1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'h0, 32'h0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);

        // Back-to-back loads with req held continuously
        access(1'b0, 32'h10, 32'h0, 1'b1);
        access(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset in WAIT of a store: dropped, no ack
        access(1'b1, 32'h20, 32'h1111_2222, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        tick();
        #1;
        chk("mid_stall", 32'(stall_o), 32'h1);
        rst = 1'b1; req = 1'b0;
        tick();
        chk("mid_rst_ack", 32'(ack_o), 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_rdata", rdata_o, 32'h0);
        chk("mid_rst_stall", 32'(stall_o), 32'h0);
        rst = 1'b0;
        rdata_m = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_no_ack", 32'(ack_o), 32'h0);
        end
        access(1'b0, 32'h20, 32'h0, 1'b0);
        chk("mid_prior", rdata_o, 32'h1111_2222);

        // Random accesses against the model
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            w = (written.size() == 0) ? 1'b1 : 1'($urandom);
            if (r < 2) begin
                a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            end else if (r < 3) begin
                a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
            end else if (w) begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
            end
            access(w, a, $urandom, (i < 39) ? 1'($urandom) : 1'b0);
        end

        // Latency-1 instance
        access1(1'b1, 32'h8, 32'h5A5A_0101, 32'h0);
        access1(1'b0, 32'h8, 32'h0, 32'h5A5A_0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
